fig_04b_rom_fetch_responder: RTL

//  ROM-side responder for the instruction-cache line-fill request. Accepts a line fetch (fetch_req/fetch_addr),

---
 rtl/superfx_rom_pkg.sv | 20 ++
 rtl/rom_wait_timer.sv | 37 +++
 rtl/fig_04b_rom_fetch_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/superfx_rom_pkg.sv
// Shared types and defaults for the ROM line-fill responder: FSM encoding,
// wait/line/address defaults and the wait-counter width helper.
package superfx_rom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } rom_fsm_t;

  localparam int ROM_WAIT_DEFAULT = 5;
  localparam int CACHE_LINE_BYTES = 16;
  localparam int ROM_ADDR_W       = 24;

  // The counter only ever holds WAIT_CYCLES-1, so WAIT_CYCLES=1 still needs one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/rom_wait_timer.sv
// Loadable down-counter timing the ROM access wait for one byte.
// zero is asserted while the count sits at 0; load takes priority over enable.
module rom_wait_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fig_04b_rom_fetch_responder.sv
// ROM-side responder for instruction-cache line fills: walks rom_a through the line,
// waits the ROM access time per byte and strobes bytes back in order.
// Optional ROM_ABORT_EN adds fetch_abort to cancel a fill in progress.
module fig_04b_rom_fetch_responder
  import superfx_rom_pkg::*;
#(
  parameter int  WAIT_CYCLES = ROM_WAIT_DEFAULT,
  parameter int  LINE_BYTES  = CACHE_LINE_BYTES,
  parameter int  ADDR_W      = ROM_ADDR_W,
  localparam int IDX_W       = $clog2(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ron,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic              busy,
  output logic              romrdy,
  output logic [7:0]        rom_byte,
  output logic [IDX_W-1:0]  byte_idx,
  output logic              fill_done,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_oe,
  input  logic [7:0]        rom_d
`ifdef ROM_ABORT_EN
  ,
  input  logic              fetch_abort
`endif
);

  localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BYTES - 1);

  rom_fsm_t          state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_next;
  logic              fetch_ack_q, fetch_ack_d;
  logic              busy_q, busy_d;
  logic              romrdy_q, romrdy_d;
  logic [7:0]        rom_byte_q, rom_byte_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic              fill_done_q, fill_done_d;
  logic [ADDR_W-1:0] rom_a_q, rom_a_d;
  logic              rom_oe_q, rom_oe_d;

  logic              tmr_load, tmr_enable, tmr_zero;
  logic              abort;

`ifdef ROM_ABORT_EN
  assign abort = fetch_abort;
`else
  assign abort = 1'b0;
`endif

  // The byte offset inside the line comes from idx_q, never from the request.
  logic unused_addr_bits;
  assign unused_addr_bits = ^fetch_addr[IDX_W-1:0];

  assign idx_next = idx_q + 1'b1;

  rom_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .enable (tmr_enable),
    .value  (RELOAD),
    .zero   (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rom_a_d     = rom_a_q;
    rom_oe_d    = rom_oe_q;
    busy_d      = busy_q;
    rom_byte_d  = rom_byte_q;
    byte_idx_d  = byte_idx_q;
    fetch_ack_d = 1'b0;
    romrdy_d    = 1'b0;
    fill_done_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_req && ron) begin
          state_d     = WAIT;
          idx_d       = '0;
          rom_a_d     = {fetch_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
          rom_oe_d    = 1'b1;
          busy_d      = 1'b1;
          fetch_ack_d = 1'b1;
          tmr_load    = 1'b1;
        end
      end

      WAIT: begin
        if (abort) begin
          state_d  = IDLE;
          rom_oe_d = 1'b0;
          busy_d   = 1'b0;
        end else if (!ron) begin
          state_d  = HOLD;
          rom_oe_d = 1'b0;
        end else if (!tmr_zero) begin
          tmr_enable = 1'b1;
        end else begin
          rom_byte_d = rom_d;
          byte_idx_d = idx_q;
          romrdy_d   = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d     = IDLE;
            fill_done_d = 1'b1;
            rom_oe_d    = 1'b0;
            busy_d      = 1'b0;
          end else begin
            // Only the offset bits advance, so the walk never carries out of the line.
            idx_d    = idx_next;
            rom_a_d  = {rom_a_q[ADDR_W-1:IDX_W], idx_next};
            tmr_load = 1'b1;
          end
        end
      end

      HOLD: begin
        if (abort) begin
          state_d  = IDLE;
          rom_oe_d = 1'b0;
          busy_d   = 1'b0;
        end else if (ron) begin
          // The host may have disturbed the ROM, so the current byte restarts a full wait.
          state_d  = WAIT;
          rom_oe_d = 1'b1;
          tmr_load = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        rom_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fetch_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      romrdy_q    <= 1'b0;
      rom_byte_q  <= '0;
      byte_idx_q  <= '0;
      fill_done_q <= 1'b0;
      rom_a_q     <= '0;
      rom_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fetch_ack_q <= fetch_ack_d;
      busy_q      <= busy_d;
      romrdy_q    <= romrdy_d;
      rom_byte_q  <= rom_byte_d;
      byte_idx_q  <= byte_idx_d;
      fill_done_q <= fill_done_d;
      rom_a_q     <= rom_a_d;
      rom_oe_q    <= rom_oe_d;
    end
  end

  assign fetch_ack = fetch_ack_q;
  assign busy      = busy_q;
  assign romrdy    = romrdy_q;
  assign rom_byte  = rom_byte_q;
  assign byte_idx  = byte_idx_q;
  assign fill_done = fill_done_q;
  assign rom_a     = rom_a_q;
  assign rom_oe    = rom_oe_q;

endmodule
